line_clear: RTL and testbench

- Post-landing stage downstream of the Tetris game FSM.
- Consumes the merged permanent grid after a piece lands, removes every full row, compacts the rows above it downward and returns the compacted grid.
- Reports the number of rows cleared.
- The FSM waits on done_o before spawning the next block, then loads grid_o back into its stored grid.

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/line_clear_row_full_check.sv | 11 +
 rtl/line_clear.sv | 156 +++++++++++++++
 tb/tb_line_clear.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris constants and types: grid geometry, the line_clear state
// encoding and the per-clear point values.
package tetris_pkg;

  localparam int ROWS  = 22;
  localparam int COLS  = 10;
  localparam int CNT_W = 5;

  // Row 0 is the top of the playfield, row ROWS-1 the bottom.
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } lc_state_e;

  localparam logic [15:0] PTS_SINGLE = 16'd40;
  localparam logic [15:0] PTS_DOUBLE = 16'd100;
  localparam logic [15:0] PTS_TRIPLE = 16'd300;
  localparam logic [15:0] PTS_TETRIS = 16'd1200;

  function automatic logic [15:0] line_points(input int unsigned n);
    logic [15:0] pts;
    case (n)
      0:       pts = 16'd0;
      1:       pts = PTS_SINGLE;
      2:       pts = PTS_DOUBLE;
      3:       pts = PTS_TRIPLE;
      default: pts = PTS_TETRIS;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/line_clear_row_full_check.sv
// Combinational full-row detector: a row is full when every cell is occupied.
module row_full_check #(
  parameter int COLS = 10
) (
  input  logic [COLS-1:0] row_i,
  output logic            full_o
);

  assign full_o = &row_i;

endmodule

// File: rtl/line_clear.sv
// Post-landing line clear: removes full rows, compacts the rest downward and
// keeps running line totals. Optional scoring is built with LINE_CLEAR_SCORE_EN.
//
// state | meaning
// IDLE  | waiting for start_i; captures grid_i on an accepted start
// SCAN  | one row per cycle bottom-up; non-full rows are copied down to wr
// FILL  | zeroes the cnt rows left vacant at the top
// DONE  | publishes the result and updates the running totals
module line_clear #(
  parameter int ROWS  = tetris_pkg::ROWS,
  parameter int COLS  = tetris_pkg::COLS,
  parameter int CNT_W = tetris_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [ROWS-1:0][COLS-1:0]  grid_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ROWS-1:0][COLS-1:0]  grid_o,
  output logic [CNT_W-1:0]           cleared_o,
  output logic [9:0]                 lines_total_o,
  output logic [15:0]                score_o
);

  localparam int PTR_W = $clog2(ROWS);
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

  tetris_pkg::lc_state_e state_q, state_d;

  logic [ROWS-1:0][COLS-1:0] work_q, work_d;
  logic [ROWS-1:0][COLS-1:0] grid_q, grid_d;
  logic [PTR_W-1:0]          rd_q, rd_d;
  logic [PTR_W-1:0]          wr_q, wr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          cleared_q, cleared_d;
  logic [9:0]                lines_q, lines_d;
  logic                      done_q, done_d;
  logic                      row_full;
  logic [10:0]               lines_sum;

  row_full_check #(.COLS(COLS)) u_row_full (
    .row_i  (work_q[rd_q]),
    .full_o (row_full)
  );

  assign lines_sum = {1'b0, lines_q} + 11'(cnt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= tetris_pkg::ST_IDLE;
      work_q    <= '0;
      grid_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      cleared_q <= '0;
      lines_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      grid_q    <= grid_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      cleared_q <= cleared_d;
      lines_q   <= lines_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    grid_d    = grid_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    cleared_d = cleared_q;
    lines_d   = lines_q;
    done_d    = 1'b0;

    unique case (state_q)
      tetris_pkg::ST_IDLE: begin
        // The done_o cycle is still part of the finished operation, so a
        // start seen there is dropped rather than starting a new pass.
        if (start_i && !done_q) begin
          work_d  = grid_i;
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          cnt_d   = '0;
          state_d = tetris_pkg::ST_SCAN;
        end
      end

      tetris_pkg::ST_SCAN: begin
        if (row_full) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // wr never sits above rd, so the copy only ever moves a row down.
          work_d[wr_q] = work_q[rd_q];
          wr_d         = wr_q - 1'b1;
        end
        rd_d = rd_q - 1'b1;
        if (rd_q == '0) begin
          state_d = (cnt_d != '0) ? tetris_pkg::ST_FILL : tetris_pkg::ST_DONE;
        end
      end

      tetris_pkg::ST_FILL: begin
        work_d[wr_q] = '0;
        wr_d         = wr_q - 1'b1;
        if (wr_q == '0) begin
          state_d = tetris_pkg::ST_DONE;
        end
      end

      tetris_pkg::ST_DONE: begin
        done_d    = 1'b1;
        grid_d    = work_q;
        cleared_d = cnt_q;
        lines_d   = lines_sum[10] ? 10'h3FF : lines_sum[9:0];
        state_d   = tetris_pkg::ST_IDLE;
      end

      default: state_d = tetris_pkg::ST_IDLE;
    endcase
  end

  assign busy_o        = (state_q != tetris_pkg::ST_IDLE) || done_q;
  assign done_o        = done_q;
  assign grid_o        = grid_q;
  assign cleared_o     = cleared_q;
  assign lines_total_o = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + {1'b0, tetris_pkg::line_points(32'(cnt_q))};

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else if (state_q == tetris_pkg::ST_DONE) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score_o = score_q;
`else
  assign score_o = '0;
`endif

endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear: a table of grids with hand-derived results
// plus reset, held-start, input-toggle and saturation sequences.
module tb_line_clear;
  import tetris_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  grid_t       grid_i;
  logic        busy_o;
  logic        done_o;
  grid_t       grid_o;
  logic [4:0]  cleared_o;
  logic [9:0]  lines_total_o;
  logic [15:0] score_o;

  line_clear dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .grid_i        (grid_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .grid_o        (grid_o),
    .cleared_o     (cleared_o),
    .lines_total_o (lines_total_o),
    .score_o       (score_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    grid_t grid;
    grid_t exp_grid;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_lines = 0;
  int   exp_score = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_grid(input string name, input grid_t act, input grid_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pts(input int n);
    if (n == 0) return 0;
    if (n == 1) return 40;
    if (n == 2) return 100;
    if (n == 3) return 300;
    return 1200;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    exp_lines = 0;
    exp_score = 0;
  endtask

  // One operation: start, measure edges from accept to done_o, check results.
  task automatic run_op(input string name, input grid_t g, input grid_t e,
                        input int cnt, input bit hold, input bit toggle);
    int lat;
    int extra;
    @(negedge clk);
    grid_i  = g;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
    chk({name, " busy_after_start"}, busy_o, 1);
    lat = 0;
    while (!done_o && lat < 200) begin
      if (toggle) grid_i = ~grid_i;
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lines = (exp_lines + cnt > 1023) ? 1023 : exp_lines + cnt;
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = (exp_score + pts(cnt) > 65535) ? 65535 : exp_score + pts(cnt);
`else
    exp_score = 0;
`endif
    chk({name, " latency"}, lat, 1 + ROWS + cnt);
    chk({name, " cleared"}, cleared_o, cnt);
    chk_grid({name, " grid"}, grid_o, e);
    chk({name, " lines_total"}, lines_total_o, exp_lines);
    chk({name, " score"}, score_o, exp_score);
    chk({name, " busy_in_done"}, busy_o, 1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk({name, " done_one_cycle"}, done_o, 0);
    chk({name, " idle_after"}, busy_o, 0);
    if (hold) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done_o) extra++;
      end
      chk({name, " no_extra_done"}, extra, 0);
      chk_grid({name, " grid_held"}, grid_o, e);
    end
  endtask

  initial begin
    int cnt_done;
    reset   = 1'b1;
    start_i = 1'b0;
    grid_i  = '0;

    for (int i = 0; i < 7; i++) begin
      vecs[i].grid     = '0;
      vecs[i].exp_grid = '0;
    end
    vecs[0].name = "empty";
    vecs[0].exp_cnt = 0;

    vecs[1].name = "single_bottom";
    vecs[1].grid[21] = 10'h3FF;
    vecs[1].grid[20] = 10'h001;
    vecs[1].exp_grid[21] = 10'h001;
    vecs[1].exp_cnt = 1;

    vecs[2].name = "four_interleaved";
    vecs[2].grid[21] = 10'h3FF;
    vecs[2].grid[20] = 10'h201;
    vecs[2].grid[19] = 10'h3FF;
    vecs[2].grid[18] = 10'h0F0;
    vecs[2].grid[17] = 10'h3FF;
    vecs[2].grid[16] = 10'h00F;
    vecs[2].grid[15] = 10'h3FF;
    vecs[2].exp_grid[21] = 10'h201;
    vecs[2].exp_grid[20] = 10'h0F0;
    vecs[2].exp_grid[19] = 10'h00F;
    vecs[2].exp_cnt = 4;

    vecs[3].name = "all_full";
    for (int r = 0; r < ROWS; r++) vecs[3].grid[r] = 10'h3FF;
    vecs[3].exp_cnt = 22;

    vecs[4].name = "top_row_full";
    vecs[4].grid[0]  = 10'h3FF;
    vecs[4].grid[5]  = 10'h155;
    vecs[4].grid[21] = 10'h2AA;
    vecs[4].exp_grid[5]  = 10'h155;
    vecs[4].exp_grid[21] = 10'h2AA;
    vecs[4].exp_cnt = 1;

    vecs[5].name = "no_full_rows";
    vecs[5].grid[10] = 10'h3FE;
    vecs[5].grid[21] = 10'h001;
    vecs[5].exp_grid[10] = 10'h3FE;
    vecs[5].exp_grid[21] = 10'h001;
    vecs[5].exp_cnt = 0;

    vecs[6].name = "top_and_bottom_full";
    vecs[6].grid[0]  = 10'h3FF;
    vecs[6].grid[21] = 10'h3FF;
    vecs[6].grid[10] = 10'h123;
    vecs[6].grid[20] = 10'h0AB;
    vecs[6].exp_grid[11] = 10'h123;
    vecs[6].exp_grid[21] = 10'h0AB;
    vecs[6].exp_cnt = 2;

    // Reset state after idling.
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk_grid("rst grid", grid_o, '0);
    chk("rst cleared", cleared_o, 0);
    chk("rst lines", lines_total_o, 0);
    chk("rst score", score_o, 0);

    // Reset in the middle of SCAN abandons the operation.
    @(negedge clk);
    grid_i  = vecs[3].grid;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midscan busy", busy_o, 0);
    chk("midscan done", done_o, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt_done = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done_o) cnt_done++;
    end
    chk("midscan no_done", cnt_done, 0);
    chk("midscan lines", lines_total_o, 0);
    chk_grid("midscan grid", grid_o, '0);

    // Table of directed grids.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].grid, vecs[i].exp_grid, vecs[i].exp_cnt, 1'b0, 1'b0);
    end

    // start_i held high across the whole operation, including the done cycles.
    run_op("held_start", vecs[1].grid, vecs[1].exp_grid, 1, 1'b1, 1'b0);

    // grid_i toggled every cycle after capture must not disturb the result.
    run_op("toggle_input", vecs[6].grid, vecs[6].exp_grid, 2, 1'b0, 1'b1);

    // Repeated 4-line clears drive both totals into saturation.
    do_reset();
    for (int op = 1; op <= 257; op++) begin
      run_op("sat", vecs[2].grid, vecs[2].exp_grid, 4, 1'b0, 1'b0);
`ifdef LINE_CLEAR_SCORE_EN
      if (op == 54) chk("score_before_cap", score_o, 16'd64800);
      if (op == 55) chk("score_cap", score_o, 16'hFFFF);
`else
      if (op == 55) chk("score_disabled", score_o, 16'h0000);
`endif
      if (op == 255) chk("lines_before_cap", lines_total_o, 10'd1020);
      if (op == 256) chk("lines_cap", lines_total_o, 10'd1023);
      if (op == 257) chk("lines_stay_capped", lines_total_o, 10'd1023);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
